shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier for the UART calculator datapath. It starts when the parser signals that the operands are valid. It computes src1*src2 over WIDTH iterations, one bit per clock. It returns the product on calc_res with a one-cycle multi_done pulse to the ALU/result logic.

---
 rtl/shift_add_multiplier.sv | 98 +++++++++
 tb/tb_shift_add_multiplier.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// WIDTH iterations per product, one-cycle multi_done pulse on completion.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic               parser_done,
  output logic [2*WIDTH:0]   calc_res,
  output logic               multi_done
);

  localparam int RW = 2 * WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is kept as a named internal signal so checkers can bind to it
  state_t          state;
  state_t          state_next;
  logic            parser_done_d;
  logic            start;
  logic            last_iter;
  logic [RW-1:0]   mcand;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   acc_sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;

  // Only a fresh low->high edge while idle starts a multiply; edges while busy are dropped.
  assign start     = parser_done & ~parser_done_d & (state == IDLE);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    acc_sum = acc;
    if (mplier[0]) acc_sum = acc + mcand;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      parser_done_d <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
      calc_res      <= '0;
      multi_done    <= 1'b0;
    end else begin
      parser_done_d <= parser_done;
      case (state)
        IDLE: begin
          multi_done <= 1'b0;
          if (start) begin
            mcand  <= {{(WIDTH + 1){1'b0}}, src1};
            mplier <= src2;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The final add lands in calc_res directly, in the same cycle.
          if (last_iter) begin
            calc_res   <= acc_sum;
            multi_done <= 1'b1;
          end
        end
        DONE: multi_done <= 1'b0;
        default: multi_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: randomized and directed
// multiplies checked against a plain a*b reference held in an expected queue.
module tb_shift_add_multiplier;

  localparam int WIDTH   = 16;
  localparam int RW      = 2 * WIDTH + 1;
  localparam int LATENCY = 17;  // cycles from raising parser_done (at a negedge) to seeing multi_done

  logic             clk;
  logic             n_rst;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             parser_done;
  logic [RW-1:0]    calc_res;
  logic             multi_done;

  int n_checks;
  int n_fail;
  int cyc;
  int pulse_cnt;
  int start_cyc;
  logic [RW-1:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .src1(src1),
    .src2(src2),
    .parser_done(parser_done),
    .calc_res(calc_res),
    .multi_done(multi_done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (multi_done === 1'b1) pulse_cnt <= pulse_cnt + 1;

  function automatic logic [RW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return RW'(p);
  endfunction

  // driver: drop parser_done for a cycle, then raise it with new operands
  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    parser_done = 1'b0;
    @(negedge clk);
    src1 = a;
    src2 = b;
    parser_done = 1'b1;
    start_cyc = cyc;
    exp_q.push_back(ref_mul(a, b));
  endtask

  task automatic wait_done(output bit got, output int lat, output logic [RW-1:0] res);
    got = 1'b0;
    lat = -1;
    res = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (multi_done === 1'b1) begin
        got = 1'b1;
        lat = cyc - start_cyc;
        res = calc_res;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    int p0;
    #1;
    n_checks++;
    if (calc_res !== '0 || multi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: calc_res=%h multi_done=%b, want 0/0", calc_res, multi_done);
    end
    @(negedge clk);
    n_rst = 1'b0;
    p0 = pulse_cnt;
    idle_cycles(20);
    n_checks++;
    if (pulse_cnt !== p0 || calc_res !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: pulses=%0d calc_res=%h, want 0 pulses and 0", pulse_cnt - p0, calc_res);
    end
    // mid-operation, mid-cycle asynchronous reset
    do_start(16'h0007, 16'h0007);
    void'(exp_q.pop_back());
    idle_cycles(3);
    #2 n_rst = 1'b1;
    #1;
    n_checks++;
    if (calc_res !== '0 || multi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: calc_res=%h multi_done=%b, want 0/0", calc_res, multi_done);
    end
    parser_done = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    idle_cycles(25);
    n_checks++;
    if (pulse_cnt !== p0) begin
      n_fail++;
      $display("FAIL reset_abort_pulse: pulses=%0d want 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_basic();
    bit got;
    int lat;
    int p0;
    logic [RW-1:0] res;
    logic [RW-1:0] exp;
    p0 = pulse_cnt;
    do_start(16'h0009, 16'h0002);
    idle_cycles(5);
    parser_done = 1'b0;
    wait_done(got, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (!got || lat !== LATENCY || res !== exp || exp !== 33'h000000012) begin
      n_fail++;
      $display("FAIL basic: got=%0b lat=%0d res=%h, want lat=%0d res=%h", got, lat, res, LATENCY, exp);
    end
    idle_cycles(20);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin
      n_fail++;
      $display("FAIL basic_single_pulse: pulses=%0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] ta [3] = '{16'hFFFF, 16'h0000, 16'h8000};
    logic [WIDTH-1:0] tb [3] = '{16'hFFFF, 16'h1234, 16'h0002};
    logic [RW-1:0]    tr [3] = '{33'h0FFFE0001, 33'h000000000, 33'h000010000};
    bit got;
    int lat;
    logic [RW-1:0] res;
    logic [RW-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      do_start(ta[i], tb[i]);
      wait_done(got, lat, res);
      exp = exp_q.pop_front();
      n_checks++;
      if (!got || lat !== LATENCY || res !== exp || res !== tr[i] || res[RW-1] !== 1'b0) begin
        n_fail++;
        $display("FAIL extreme_%0d: got=%0b lat=%0d res=%h, want lat=%0d res=%h", i, got, lat, res, LATENCY, tr[i]);
      end
    end
  endtask

  task automatic test_random();
    bit got;
    int lat;
    int bad;
    logic [RW-1:0] res;
    logic [RW-1:0] exp;
    for (int i = 0; i < 25; i++) begin
      do_start(WIDTH'($urandom), WIDTH'($urandom));
      idle_cycles($urandom_range(1, 10));
      parser_done = 1'b0;
      wait_done(got, lat, res);
      exp = exp_q.pop_front();
      n_checks++;
      if (!got || lat !== LATENCY || res !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: got=%0b lat=%0d res=%h, want lat=%0d res=%h", i, got, lat, res, LATENCY, exp);
      end
      bad = $urandom_range(0, 3);
      idle_cycles(bad);
    end
  endtask

  task automatic test_busy();
    bit got;
    int lat;
    int p0;
    logic [RW-1:0] res;
    logic [RW-1:0] exp;
    p0 = pulse_cnt;
    do_start(16'h0003, 16'h0005);
    idle_cycles(3);
    parser_done = 1'b0;
    src1 = WIDTH'($urandom);
    src2 = WIDTH'($urandom);
    idle_cycles(2);
    parser_done = 1'b1;
    src1 = 16'hFFFF;
    idle_cycles(2);
    parser_done = 1'b0;
    idle_cycles(2);
    parser_done = 1'b1;
    wait_done(got, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (!got || lat !== LATENCY || res !== exp || res !== 33'h00000000F) begin
      n_fail++;
      $display("FAIL busy: got=%0b lat=%0d res=%h, want lat=%0d res=%h", got, lat, res, LATENCY, exp);
    end
    parser_done = 1'b0;
    idle_cycles(25);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin
      n_fail++;
      $display("FAIL busy_single_pulse: pulses=%0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int lat;
    bit held_ok;
    logic [RW-1:0] res;
    logic [RW-1:0] exp;
    logic [RW-1:0] prev;
    do_start(16'h0011, 16'h0003);
    wait_done(got, lat, res);
    prev = exp_q.pop_front();
    n_checks++;
    if (!got || res !== prev) begin
      n_fail++;
      $display("FAIL b2b_first: got=%0b res=%h want %h", got, res, prev);
    end
    do_start(16'h00FF, 16'h0100);
    held_ok = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (multi_done === 1'b1) begin
        got = 1'b1;
        lat = cyc - start_cyc;
        res = calc_res;
        break;
      end
      if (calc_res !== prev) held_ok = 1'b0;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL b2b_hold: calc_res changed before pulse, want held %h", prev);
    end
    n_checks++;
    if (!got || lat !== LATENCY || res !== exp || res !== 33'h00000FF00) begin
      n_fail++;
      $display("FAIL b2b_second: got=%0b lat=%0d res=%h, want lat=%0d res=%h", got, lat, res, LATENCY, exp);
    end
  endtask

  task automatic test_abort();
    bit got;
    int lat;
    int p0;
    logic [RW-1:0] res;
    logic [RW-1:0] exp;
    do_start(16'h1234, 16'h5678);
    void'(exp_q.pop_back());
    idle_cycles(8);
    #3 n_rst = 1'b1;
    #1;
    n_checks++;
    if (calc_res !== '0 || multi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: calc_res=%h multi_done=%b, want 0/0", calc_res, multi_done);
    end
    parser_done = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    p0 = pulse_cnt;
    idle_cycles(25);
    n_checks++;
    if (pulse_cnt !== p0 || calc_res !== '0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: pulses=%0d calc_res=%h, want 0/0", pulse_cnt - p0, calc_res);
    end
    do_start(16'h1234, 16'h5678);
    wait_done(got, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (!got || lat !== LATENCY || res !== exp || res !== 33'h006260060) begin
      n_fail++;
      $display("FAIL abort_restart: got=%0b lat=%0d res=%h, want lat=%0d res=%h", got, lat, res, LATENCY, exp);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    pulse_cnt   = 0;
    start_cyc   = 0;
    n_rst       = 1'b1;
    src1        = '0;
    src2        = '0;
    parser_done = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_busy();
    test_back_to_back();
    test_abort();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
